// File: rtl/sdram_rom_arb.sv
// Fixed-priority sequencer sharing one SDRAM port between C/S/P ROM reads and
// HPS download writes, with latched request addresses and a ready watchdog.
module sdram_rom_arb #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk_sys,
    input  logic        nRESET,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [15:0] dl_data,
    output logic        dl_wait,
    input  logic        crom_trig,
    input  logic        srom_trig,
    input  logic        prom_sel,
    input  logic        prom_sys,
    input  logic [18:0] spr_addr,
    input  logic [15:0] fix_addr,
    input  logic [18:0] m68k_addr,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic        sd_rd,
    output logic        sd_we,
    input  logic [15:0] sd_dout,
    input  logic        sd_ready,
    output logic [31:0] cr_data,
    output logic        crom_valid,
    output logic [15:0] srom_data,
    output logic        srom_valid,
    output logic [15:0] prom_data,
    output logic        prom_valid,
    output logic        err_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;
    typedef enum logic [1:0] {CLS_C, CLS_S, CLS_P} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [1:0]  crom_sh_q, srom_sh_q, prom_sh_q;
    logic        dl_act_q;
    logic        crom_pend_q, srom_pend_q, prom_pend_q;
    logic [18:0] spr_q, m68k_q;
    logic [15:0] fix_q;
    logic        sys_q;
    logic        step_q;
    logic [24:0] addr_q, rd_addr_d;
    logic [15:0] din_q, shadow_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] cr_data_q;
    logic [15:0] srom_data_q, prom_data_q;
    logic        crom_valid_q, srom_valid_q, prom_valid_q, err_q;
    logic        wr_hold_q;
    logic [24:0] wr_addr_q;
    logic [15:0] wr_data_q;
    logic        go_rd, go_wr, rd_done, wr_done, tmo;

    wire crom_edge = crom_sh_q[0] & ~crom_sh_q[1] & ~dl_active;
    wire srom_edge = srom_sh_q[0] & ~srom_sh_q[1] & ~dl_active;
    wire prom_edge = prom_sh_q[0] & ~prom_sh_q[1] & ~dl_active;
    wire dl_start  = dl_active & ~dl_act_q;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        go_rd   = 1'b0;
        go_wr   = 1'b0;
        rd_done = 1'b0;
        wr_done = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_hold_q) begin
                    state_d = WR_ISSUE;
                    go_wr   = 1'b1;
                end else if (crom_pend_q) begin
                    state_d = RD_ISSUE;
                    go_rd   = 1'b1;
                    cls_d   = CLS_C;
                end else if (srom_pend_q) begin
                    state_d = RD_ISSUE;
                    go_rd   = 1'b1;
                    cls_d   = CLS_S;
                end else if (prom_pend_q) begin
                    state_d = RD_ISSUE;
                    go_rd   = 1'b1;
                    cls_d   = CLS_P;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (sd_ready) begin
                    rd_done = 1'b1;
                    // second C ROM word follows immediately, nothing may slip in
                    state_d = (cls_q == CLS_C && !step_q) ? RD_ISSUE : IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            WR_WAIT: begin
                if (sd_ready) begin
                    wr_done = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (cls_d)
            CLS_C:   rd_addr_d = {4'b0010, spr_q, 1'b0, 1'b0};
            CLS_S:   rd_addr_d = {8'b00010000, fix_q, 1'b0};
            default: rd_addr_d = sys_q ? {5'b01110, m68k_q, 1'b0} : {5'b00000, m68k_q, 1'b0};
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            state_q      <= IDLE;
            cls_q        <= CLS_C;
            crom_sh_q    <= '0;
            srom_sh_q    <= '0;
            prom_sh_q    <= '0;
            dl_act_q     <= 1'b0;
            crom_pend_q  <= 1'b0;
            srom_pend_q  <= 1'b0;
            prom_pend_q  <= 1'b0;
            spr_q        <= '0;
            fix_q        <= '0;
            m68k_q       <= '0;
            sys_q        <= 1'b0;
            step_q       <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            shadow_q     <= '0;
            cnt_q        <= '0;
            cr_data_q    <= '0;
            srom_data_q  <= '0;
            prom_data_q  <= '0;
            crom_valid_q <= 1'b0;
            srom_valid_q <= 1'b0;
            prom_valid_q <= 1'b0;
            err_q        <= 1'b0;
            wr_hold_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            crom_sh_q    <= {crom_sh_q[0], crom_trig};
            srom_sh_q    <= {srom_sh_q[0], srom_trig};
            prom_sh_q    <= {prom_sh_q[0], prom_sel};
            dl_act_q     <= dl_active;
            crom_valid_q <= 1'b0;
            srom_valid_q <= 1'b0;
            prom_valid_q <= 1'b0;

            if (state_q == RD_ISSUE || state_q == WR_ISSUE)
                cnt_q <= '0;
            else if (state_q == RD_WAIT || state_q == WR_WAIT)
                cnt_q <= cnt_q + 1'b1;

            // a new edge wins over the issue-clear so a retrigger is served again
            if (dl_start) crom_pend_q <= 1'b0;
            else if (crom_edge) begin
                crom_pend_q <= 1'b1;
                spr_q       <= spr_addr;
            end else if (go_rd && cls_d == CLS_C) crom_pend_q <= 1'b0;

            if (dl_start) srom_pend_q <= 1'b0;
            else if (srom_edge) begin
                srom_pend_q <= 1'b1;
                fix_q       <= fix_addr;
            end else if (go_rd && cls_d == CLS_S) srom_pend_q <= 1'b0;

            if (dl_start) prom_pend_q <= 1'b0;
            else if (prom_edge) begin
                prom_pend_q <= 1'b1;
                m68k_q      <= m68k_addr;
                sys_q       <= prom_sys;
            end else if (go_rd && cls_d == CLS_P) prom_pend_q <= 1'b0;

            if (dl_active && dl_wr && !wr_hold_q) begin
                wr_hold_q <= 1'b1;
                wr_addr_q <= dl_addr;
                wr_data_q <= dl_data;
            end

            if (go_rd) begin
                cls_q  <= cls_d;
                step_q <= 1'b0;
                addr_q <= rd_addr_d;
            end
            if (go_wr) begin
                addr_q <= wr_addr_q;
                din_q  <= wr_data_q;
            end

            if (rd_done) begin
                case (cls_q)
                    CLS_C: begin
                        if (!step_q) begin
                            shadow_q  <= sd_dout;
                            step_q    <= 1'b1;
                            addr_q[1] <= 1'b1;
                        end else begin
                            cr_data_q    <= {shadow_q, sd_dout};
                            crom_valid_q <= 1'b1;
                        end
                    end
                    CLS_S: begin
                        srom_data_q  <= sd_dout;
                        srom_valid_q <= 1'b1;
                    end
                    default: begin
                        prom_data_q  <= sd_dout;
                        prom_valid_q <= 1'b1;
                    end
                endcase
            end
            if (wr_done) wr_hold_q <= 1'b0;

            if (tmo) begin
                err_q <= 1'b1;
                if (state_q == WR_WAIT) wr_hold_q <= 1'b0;
            end

            if (state_d == IDLE) begin
                addr_q <= '0;
                din_q  <= '0;
            end
        end
    end

    assign sd_addr     = addr_q;
    assign sd_din      = din_q;
    assign sd_rd       = (state_q == RD_ISSUE);
    assign sd_we       = (state_q == WR_ISSUE);
    assign dl_wait     = wr_hold_q;
    assign cr_data     = cr_data_q;
    assign crom_valid  = crom_valid_q;
    assign srom_data   = srom_data_q;
    assign srom_valid  = srom_valid_q;
    assign prom_data   = prom_data_q;
    assign prom_valid  = prom_valid_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_sdram_rom_arb.sv
// Directed bench for sdram_rom_arb: the bench plays the SDRAM controller and
// checks addresses, ordering, data assembly, download writes and the watchdog.
module tb_sdram_rom_arb;
    localparam int TO = 63;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        dl_active = 1'b0, dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [15:0] dl_data = '0;
    logic        dl_wait;
    logic        crom_trig = 1'b0, srom_trig = 1'b0, prom_sel = 1'b0, prom_sys = 1'b0;
    logic [18:0] spr_addr = '0, m68k_addr = '0;
    logic [15:0] fix_addr = '0;
    logic [24:0] sd_addr;
    logic [15:0] sd_din;
    logic        sd_rd, sd_we;
    logic [15:0] sd_dout = '0;
    logic        sd_ready = 1'b0;
    logic [31:0] cr_data;
    logic        crom_valid, srom_valid, prom_valid;
    logic [15:0] srom_data, prom_data;
    logic        err_timeout;

    int tests = 0;
    int errors = 0;
    int crom_cnt = 0, srom_cnt = 0, prom_cnt = 0, rd_cnt = 0, we_cnt = 0;

    sdram_rom_arb #(.TIMEOUT(TO)) dut (
        .clk_sys(clk), .nRESET(nRESET),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_wait(dl_wait),
        .crom_trig(crom_trig), .srom_trig(srom_trig), .prom_sel(prom_sel), .prom_sys(prom_sys),
        .spr_addr(spr_addr), .fix_addr(fix_addr), .m68k_addr(m68k_addr),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_rd(sd_rd), .sd_we(sd_we),
        .sd_dout(sd_dout), .sd_ready(sd_ready),
        .cr_data(cr_data), .crom_valid(crom_valid),
        .srom_data(srom_data), .srom_valid(srom_valid),
        .prom_data(prom_data), .prom_valid(prom_valid),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (crom_valid) crom_cnt++;
        if (srom_valid) srom_cnt++;
        if (prom_valid) prom_cnt++;
        if (sd_rd) rd_cnt++;
        if (sd_we) we_cnt++;
    end

    // Wait for a request, check address/data, then answer with sd_ready two cycles later.
    task automatic serve(input bit wr, input logic [24:0] exp_addr, input logic [15:0] exp_din,
                         input logic [15:0] rdata, input string name, output int lat);
        int i;
        bit seen;
        seen = 1'b0;
        for (i = 0; i < 200; i++) begin
            if (wr ? sd_we : sd_rd) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = i;
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: request seen=0 required=1 within 200 cycles", name);
        end else begin
            $display("[TB] %s: %s addr=%h din=%h lat=%0d", name, wr ? "we" : "rd", sd_addr, sd_din, lat);
            tests++;
            if (sd_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s_addr: got %h expected %h", name, sd_addr, exp_addr);
            end
            if (wr) begin
                tests++;
                if (sd_din !== exp_din) begin
                    errors++;
                    $display("FAIL %s_din: got %h expected %h", name, sd_din, exp_din);
                end
            end
            @(negedge clk);
            tests++;
            if ((sd_rd | sd_we) !== 1'b0 || sd_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s_hold: rd|we=%b addr=%h expected 0 and %h", name, sd_rd | sd_we, sd_addr, exp_addr);
            end
            @(negedge clk);
            sd_dout  = rdata;
            sd_ready = 1'b1;
            @(negedge clk);
            sd_ready = 1'b0;
            sd_dout  = '0;
        end
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({sd_rd, sd_we, dl_wait, crom_valid, srom_valid, prom_valid, err_timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {sd_rd, sd_we, dl_wait, crom_valid, srom_valid, prom_valid, err_timeout});
        end
        tests++;
        if ({sd_addr, sd_din, cr_data, srom_data, prom_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h din=%h cr=%h s=%h p=%h expected all 0",
                     sd_addr, sd_din, cr_data, srom_data, prom_data);
        end
        nRESET = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_crom();
        int lat, c0;
        c0 = crom_cnt;
        spr_addr  = 19'h12345;
        crom_trig = 1'b1;
        serve(1'b0, 25'h0448D14, 16'h0, 16'hAAAA, "crom_step0", lat);
        tests++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL crom_issue_latency: got %0d expected 3", lat);
        end
        serve(1'b0, 25'h0448D16, 16'h0, 16'h5555, "crom_step1", lat);
        tests++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL crom_step1_latency: got %0d expected 0", lat);
        end
        crom_trig = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (cr_data !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL crom_data: got %h expected aaaa5555", cr_data);
        end
        tests++;
        if (crom_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL crom_valid_count: got %0d expected 1", crom_cnt - c0);
        end
    endtask

    task automatic test_priority();
        int lat, c0, s0, p0;
        c0 = crom_cnt; s0 = srom_cnt; p0 = prom_cnt;
        spr_addr  = 19'h00001;
        fix_addr  = 16'hBEEF;
        m68k_addr = 19'h01234;
        prom_sys  = 1'b0;
        crom_trig = 1'b1; srom_trig = 1'b1; prom_sel = 1'b1;
        serve(1'b0, 25'h0400004, 16'h0, 16'h1111, "prio_c0", lat);
        serve(1'b0, 25'h0400006, 16'h0, 16'h2222, "prio_c1", lat);
        serve(1'b0, 25'h0217DDE, 16'h0, 16'h3333, "prio_s", lat);
        serve(1'b0, 25'h0002468, 16'h0, 16'h4444, "prio_p", lat);
        crom_trig = 1'b0; srom_trig = 1'b0; prom_sel = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({crom_cnt - c0, srom_cnt - s0, prom_cnt - p0} !== {32'd1, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL prio_valid_counts: got c=%0d s=%0d p=%0d expected 1 1 1",
                     crom_cnt - c0, srom_cnt - s0, prom_cnt - p0);
        end
        tests++;
        if ({cr_data, srom_data, prom_data} !== {32'h11112222, 16'h3333, 16'h4444}) begin
            errors++;
            $display("FAIL prio_data: got cr=%h s=%h p=%h expected 11112222 3333 4444",
                     cr_data, srom_data, prom_data);
        end
    endtask

    task automatic test_sysrom();
        int lat, p0;
        p0 = prom_cnt;
        m68k_addr = 19'h00010;
        prom_sys  = 1'b1;
        prom_sel  = 1'b1;
        serve(1'b0, 25'h0E00020, 16'h0, 16'hC0DE, "sysrom", lat);
        prom_sel = 1'b0;
        prom_sys = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (prom_data !== 16'hC0DE || prom_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL sysrom_data: got %h count %0d expected c0de count 1", prom_data, prom_cnt - p0);
        end
    endtask

    task automatic test_download();
        int lat, r0, w0;
        logic [24:0] wa [3];
        logic [15:0] wd [3];
        wa[0] = 25'h0; wa[1] = 25'h2; wa[2] = 25'h4;
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
        r0 = rd_cnt; w0 = we_cnt;
        dl_active = 1'b1;
        repeat (2) @(negedge clk);
        crom_trig = 1'b1;
        srom_trig = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dl_addr = wa[k];
            dl_data = wd[k];
            dl_wr   = 1'b1;
            @(negedge clk);
            dl_wr = 1'b0;
            tests++;
            if (dl_wait !== 1'b1) begin
                errors++;
                $display("FAIL dl_wait_rise%0d: got %b expected 1", k, dl_wait);
            end
            serve(1'b1, wa[k], wd[k], 16'h0, $sformatf("dl_wr%0d", k), lat);
            tests++;
            if (dl_wait !== 1'b0) begin
                errors++;
                $display("FAIL dl_wait_fall%0d: got %b expected 0", k, dl_wait);
            end
        end
        crom_trig = 1'b0;
        srom_trig = 1'b0;
        repeat (3) @(negedge clk);
        dl_active = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (rd_cnt - r0 !== 0 || we_cnt - w0 !== 3) begin
            errors++;
            $display("FAIL dl_counts: got rd=%0d we=%0d expected rd=0 we=3", rd_cnt - r0, we_cnt - w0);
        end
    endtask

    task automatic test_timeout();
        int lat, s0, p0, i;
        bit seen;
        s0 = srom_cnt; p0 = prom_cnt;
        fix_addr  = 16'h0001;
        srom_trig = 1'b1;
        seen = 1'b0;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sd_rd) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || sd_addr !== 25'h0200002) begin
            errors++;
            $display("FAIL tmo_issue: seen=%b addr=%h expected 1 and 0200002", seen, sd_addr);
        end
        $display("[TB] tmo_srom: rd addr=%h, no ready", sd_addr);
        srom_trig = 1'b0;
        repeat (TO + 10) @(negedge clk);
        tests++;
        if (err_timeout !== 1'b1 || sd_addr !== 25'h0) begin
            errors++;
            $display("FAIL tmo_abort: err=%b addr=%h expected 1 and 0", err_timeout, sd_addr);
        end
        m68k_addr = 19'h00002;
        prom_sel  = 1'b1;
        serve(1'b0, 25'h0000004, 16'h0, 16'h7777, "tmo_next_p", lat);
        prom_sel = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (srom_cnt - s0 !== 0 || prom_cnt - p0 !== 1 || prom_data !== 16'h7777) begin
            errors++;
            $display("FAIL tmo_after: s=%0d p=%0d pdata=%h expected 0 1 7777",
                     srom_cnt - s0, prom_cnt - p0, prom_data);
        end
    endtask

    task automatic test_reset_mid();
        int c0, i;
        bit seen;
        c0 = crom_cnt;
        spr_addr  = 19'h00100;
        crom_trig = 1'b1;
        seen = 1'b0;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sd_rd) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_issue: request seen=0 required=1");
        end
        $display("[TB] rstmid: rd addr=%h, reset in wait", sd_addr);
        @(negedge clk);
        nRESET    = 1'b0;
        crom_trig = 1'b0;
        @(negedge clk);
        tests++;
        if ({sd_rd, sd_we, dl_wait, err_timeout, crom_valid} !== 5'b0 || sd_addr !== '0 || cr_data !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: flags=%b addr=%h cr=%h expected all 0",
                     {sd_rd, sd_we, dl_wait, err_timeout, crom_valid}, sd_addr, cr_data);
        end
        nRESET = 1'b1;
        @(negedge clk);
        sd_dout  = 16'hDEAD;
        sd_ready = 1'b1;
        @(negedge clk);
        sd_ready = 1'b0;
        sd_dout  = '0;
        repeat (6) @(negedge clk);
        tests++;
        if (crom_cnt - c0 !== 0 || cr_data !== '0 || sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_late_ready: valid count %0d cr=%h rd=%b expected 0 0 0",
                     crom_cnt - c0, cr_data, sd_rd);
        end
    endtask

    initial begin
        test_reset();
        test_crom();
        test_priority();
        test_sysrom();
        test_download();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
